// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Types and default constants shared by the UART RX/TX blocks.
//                Holds the start-bit detector state encoding and its default
//                qualification / assertion sample counts.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Start-bit detector FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DETECTED = 2'd3
  } start_det_state_t;

  // Consecutive low samples (from the first low) needed to accept a start bit.
  localparam int unsigned MIN_LOW_SAMPLES_DEFAULT = 4;
  // Edge, counted from the first low sample (=1), on which the flag rises.
  localparam int unsigned ASSERT_SAMPLE_DEFAULT   = 9;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/start_bit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : start_bit_detector
//  Description : UART RX front end. Watches the idle-high serial line (one
//                sample per clk) and qualifies a falling edge as a start bit.
//                Low glitches shorter than MIN_LOW_SAMPLES are rejected. Once
//                qualified, a sticky flag registers high on edge ASSERT_SAMPLE
//                counted from the first low sample, and holds until rst.
//  Ports       : clk                - rising-edge clock, one data sample/edge
//                rst                - synchronous active-high reset
//                data               - serial line (idle 1), already synced
//                start_bit_detected - registered sticky detection flag
//  Revision    : 1.0 - initial release
// ============================================================================
module start_bit_detector
  import uart_pkg::*;
#(
  parameter int unsigned MIN_LOW_SAMPLES = MIN_LOW_SAMPLES_DEFAULT,
  parameter int unsigned ASSERT_SAMPLE   = ASSERT_SAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic data,
  output logic start_bit_detected
);

  localparam int unsigned CNT_W = $clog2(ASSERT_SAMPLE + 1);

  localparam logic [CNT_W-1:0] C_ONE_CNT    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN_CNT    = CNT_W'(MIN_LOW_SAMPLES);
  localparam logic [CNT_W-1:0] C_ASSERT_CNT = CNT_W'(ASSERT_SAMPLE);

  generate
    if ((MIN_LOW_SAMPLES < 1) || (MIN_LOW_SAMPLES > ASSERT_SAMPLE)) begin : g_param_check
      $error("start_bit_detector: need 1 <= MIN_LOW_SAMPLES <= ASSERT_SAMPLE");
    end
  endgenerate

  start_det_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment: the counter never wraps past ASSERT_SAMPLE.
  assign w_cnt_inc = (cnt_q >= C_ASSERT_CNT) ? cnt_q : (cnt_q + C_ONE_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!data) begin
          // First low sample counts as sample 1. Small parameter values may
          // already satisfy qualification or assertion on this very edge.
          cnt_d = C_ONE_CNT;
          if (C_ONE_CNT >= C_ASSERT_CNT) begin
            state_d = ST_DETECTED;
          end else if (C_ONE_CNT >= C_MIN_CNT) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_QUALIFY;
          end
        end
      end

      ST_QUALIFY: begin
        if (data) begin
          // Glitch: fully re-arm so a real start bit right after is not lost.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc >= C_ASSERT_CNT) begin
            state_d = ST_DETECTED;
          end else if (w_cnt_inc >= C_MIN_CNT) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Line value is irrelevant here; only the sampling point matters.
        cnt_d = w_cnt_inc;
        if (w_cnt_inc >= C_ASSERT_CNT) begin
          state_d = ST_DETECTED;
        end
      end

      ST_DETECTED: begin
        state_d = ST_DETECTED;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flag tracks the registered state so it rises on the same edge the FSM
    // enters DETECTED and stays high as long as the FSM remains there.
    flag_d = (state_d == ST_DETECTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign start_bit_detected = flag_q;

endmodule : start_bit_detector
`default_nettype wire

// File: tb/tb_start_bit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_start_bit_detector
//  Description : Self-checking bench for start_bit_detector. Each driven
//                sample pushes the behaviourally expected flag into a
//                scoreboard queue; after the following rising edge the
//                registered output is popped and compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_start_bit_detector;

  localparam int unsigned C_MIN_LOW = 4;
  localparam int unsigned C_ASSERT  = 9;

  logic clk;
  logic rst;
  logic data;
  logic start_bit_detected;

  int   n_checks;
  int   n_errors;
  logic exp_q[$];

  // Reference model: position within the current low event (0 = idle) and
  // the sticky detection flag.
  int   m_pos;
  logic m_det;

  start_bit_detector #(
    .MIN_LOW_SAMPLES(C_MIN_LOW),
    .ASSERT_SAMPLE  (C_ASSERT)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .data              (data),
    .start_bit_detected(start_bit_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #60us;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one sampled edge.
  task automatic model_step(input logic r, input logic d);
    if (r) begin
      m_pos = 0;
      m_det = 1'b0;
    end else if (!m_det) begin
      if (m_pos == 0) begin
        if (!d) m_pos = 1;
      end else if (m_pos < int'(C_MIN_LOW)) begin
        if (d) m_pos = 0;
        else   m_pos = m_pos + 1;
      end else begin
        m_pos = m_pos + 1;
      end
      if (m_pos >= int'(C_ASSERT)) m_det = 1'b1;
    end
  endtask

  // Drive one sample between edges, record its expectation, then compare
  // the registered output shortly after the edge that samples it.
  task automatic drive_cycle(input string tag, input logic r, input logic d);
    logic exp;
    @(negedge clk);
    rst  = r;
    data = d;
    model_step(r, d);
    exp_q.push_back(m_det);
    @(posedge clk);
    #2;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty scoreboard required one entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, start_bit_detected, exp);
    end
  endtask

  task automatic drive_run(input string tag, input logic d, input int n);
    for (int i = 0; i < n; i++) drive_cycle(tag, 1'b0, d);
  endtask

  task automatic do_reset(input string tag);
    drive_cycle(tag, 1'b1, 1'b1);
  endtask

  initial begin
    int glitch_len;
    int gap_len;
    int low_len;

    n_checks = 0;
    n_errors = 0;
    m_pos    = 0;
    m_det    = 1'b0;
    rst      = 1'b1;
    data     = 1'b1;

    // stays_in_reset
    for (int i = 0; i < 20; i++) drive_cycle("stays_in_reset_hi", 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) drive_cycle("stays_in_reset_lo", 1'b1, 1'b0);

    // detects_short_start_bit
    do_reset("short_rst");
    drive_run("short_idle", 1'b1, 2);
    drive_run("short_low", 1'b0, 4);
    drive_run("short_high", 1'b1, 24);

    // detects_long_start_bit
    do_reset("long_rst");
    drive_run("long_low", 1'b0, 58);
    drive_run("long_high", 1'b1, 50);

    // rejects_spurious_pulse
    do_reset("spurious_rst");
    drive_run("spurious_low", 1'b0, 3);
    drive_run("spurious_high", 1'b1, 20);

    // detects_start_after_spurious_pulse
    do_reset("after_rst");
    drive_run("after_glitch", 1'b0, 3);
    drive_run("after_gap", 1'b1, 10);
    drive_run("after_low", 1'b0, 4);
    drive_run("after_high", 1'b1, 24);

    // Randomised glitch lengths followed by a valid start bit.
    for (int k = 0; k < 8; k++) begin
      glitch_len = int'($urandom_range(1, 3));
      gap_len    = int'($urandom_range(1, 5));
      low_len    = int'($urandom_range(4, 12));
      do_reset("rand_rst");
      drive_run("rand_idle", 1'b1, 2);
      drive_run("rand_glitch", 1'b0, glitch_len);
      drive_run("rand_gap", 1'b1, gap_len);
      drive_run("rand_low", 1'b0, low_len);
      drive_run("rand_high", 1'b1, 15);
    end

    // Reset must clear a detected flag.
    drive_cycle("final_rst", 1'b1, 1'b0);
    drive_run("final_idle", 1'b1, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_start_bit_detector
`default_nettype wire
